// File: rtl/d_latch_if.sv
// Data-side bundle of the d_latch: D in, true and complementary outputs back.
// master drives D and observes Q/Qb; slave is the latch itself.
interface d_latch_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qb;

  modport master (output D, input Q, input Qb);
  modport slave  (input D, output Q, output Qb);
endinterface

// File: rtl/d_latch.sv
// Level-sensitive D latch, WIDTH independent bits sharing one enable (CLK) and
// an enable-qualified active-low reset. Transparent while CLK = 1, holding while CLK = 0.
module d_latch #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic        CLK,
  input  logic        RSTn,
  d_latch_if.slave    bus
);

  logic [WIDTH-1:0] q_l;

  // Reset only acts through the open enable, so RSTn low during hold leaves Q alone
  // and a falling CLK with RSTn low keeps RESET_VALUE for the whole hold phase.
  always_latch begin
    if (CLK) begin
      if (!RSTn) q_l <= RESET_VALUE;
      else       q_l <= bus.D;
    end
  end

  assign bus.Q  = q_l;
  assign bus.Qb = ~q_l;

endmodule

// File: tb/tb_d_latch.sv
// Bench for d_latch: directed level-sensitivity scenarios followed by random
// single-signal steps, all compared against a transparent/hold model.
module tb_d_latch;
  localparam int             W    = 4;
  localparam logic [W-1:0]   RV_A = 4'b0000;
  localparam logic [W-1:0]   RV_B = 4'b1001;

  logic         CLK;
  logic         RSTn;
  logic [W-1:0] din;

  d_latch_if #(.WIDTH(W)) bus_a ();
  d_latch_if #(.WIDTH(W)) bus_b ();

  assign bus_a.D = din;
  assign bus_b.D = din;

  d_latch #(.WIDTH(W), .RESET_VALUE(RV_A)) u_a (.CLK(CLK), .RSTn(RSTn), .bus(bus_a));
  d_latch #(.WIDTH(W), .RESET_VALUE(RV_B)) u_b (.CLK(CLK), .RSTn(RSTn), .bus(bus_b));

  int           vectors     = 0;
  int           miscompares = 0;
  int           hold_events = 0;
  bit           known       = 0;
  bit           done        = 0;
  logic [W-1:0] mq_a, mq_b;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Only one of CLK/RSTn/D changes per 4 ns slot, so D and RSTn never move with a CLK edge.
  task automatic apply(input int kind, input logic [W-1:0] v);
    #2;
    case (kind)
      0:       CLK  = v[0];
      1:       RSTn = v[0];
      default: din  = v;
    endcase
    #2;
  endtask

  task automatic expect_q(input string name, input logic [W-1:0] ea, input logic [W-1:0] eb);
    check({name, "_qa"},  bus_a.Q,  ea);
    check({name, "_qba"}, bus_a.Qb, ~ea);
    check({name, "_qb"},  bus_b.Q,  eb);
    check({name, "_qbb"}, bus_b.Qb, ~eb);
  endtask

  // Any output event while the enable is low is a hold-phase glitch.
  always @(bus_a.Q or bus_b.Q) begin
    if (CLK === 1'b0 && $time > 0) hold_events++;
  end

  // Model: open enable defines Q (reset wins), closed enable keeps the last value.
  initial begin
    while (!done) begin
      #4;
      if (CLK === 1'b1) begin
        known = 1;
        mq_a  = RSTn ? din : RV_A;
        mq_b  = RSTn ? din : RV_B;
      end
      if (known && !done) begin
        check("model_qa",  bus_a.Q,  mq_a);
        check("model_qba", bus_a.Qb, ~mq_a);
        check("model_qb",  bus_b.Q,  mq_b);
        check("model_qbb", bus_b.Qb, ~mq_b);
      end
    end
  end

  initial begin
    CLK  = 1'b0;
    RSTn = 1'b1;
    din  = '0;

    // Transparency
    apply(0, 4'd1);               expect_q("open",    4'b0000, 4'b0000);
    apply(2, 4'b0001);            expect_q("tr1",     4'b0001, 4'b0001);
    apply(2, 4'b0000);            expect_q("tr0",     4'b0000, 4'b0000);
    apply(2, 4'b0001);            expect_q("tr1b",    4'b0001, 4'b0001);

    // Hold: D toggles while closed
    apply(0, 4'd0);               expect_q("hold",    4'b0001, 4'b0001);
    apply(2, 4'b0000);            expect_q("hold_d0", 4'b0001, 4'b0001);
    apply(2, 4'b0001);            expect_q("hold_d1", 4'b0001, 4'b0001);
    apply(2, 4'b0000);            expect_q("hold_d2", 4'b0001, 4'b0001);

    // Re-open with D = 0
    apply(0, 4'd1);               expect_q("reopen",  4'b0000, 4'b0000);

    // Reset in transparent phase
    apply(2, 4'b0001);            expect_q("pre_rst", 4'b0001, 4'b0001);
    apply(1, 4'd0);               expect_q("rst_tr",  RV_A,    RV_B);
    apply(2, 4'b0110);            expect_q("rst_d0",  RV_A,    RV_B);
    apply(2, 4'b0001);            expect_q("rst_d1",  RV_A,    RV_B);
    apply(1, 4'd1);               expect_q("rst_rel", 4'b0001, 4'b0001);

    // Reset in hold phase
    apply(0, 4'd0);               expect_q("h_q1",    4'b0001, 4'b0001);
    apply(1, 4'd0);               expect_q("h_rst",   4'b0001, 4'b0001);
    apply(1, 4'd1);               expect_q("h_rstup", 4'b0001, 4'b0001);
    apply(1, 4'd0);               expect_q("h_rst2",  4'b0001, 4'b0001);
    apply(0, 4'd1);               expect_q("open_rst", RV_A,   RV_B);
    apply(0, 4'd0);               expect_q("fall_rst", RV_A,   RV_B);
    apply(2, 4'b1111);            expect_q("hold_rv",  RV_A,   RV_B);
    apply(1, 4'd1);               expect_q("hold_rv2", RV_A,   RV_B);

    // Multi-bit capture
    apply(2, 4'b1010);            expect_q("mb_closed", RV_A,  RV_B);
    apply(0, 4'd1);               expect_q("mb_open", 4'b1010, 4'b1010);
    apply(0, 4'd0);               expect_q("mb_fall", 4'b1010, 4'b1010);
    apply(2, 4'b0101);            expect_q("mb_hold", 4'b1010, 4'b1010);
    apply(0, 4'd1);               expect_q("mb_reop", 4'b0101, 4'b0101);

    // Random single-signal steps
    for (int i = 0; i < 3000; i++) begin
      int kind;
      kind = $urandom_range(0, 4);
      case (kind)
        0, 1:    apply(0, {3'b000, ~CLK});
        2:       apply(1, {3'b000, ~RSTn});
        default: apply(2, W'($urandom));
      endcase
    end

    vectors++;
    if (hold_events != 0) begin
      miscompares++;
      $display("FAIL hold_glitch: got %0d Q events while closed, expected 0", hold_events);
    end

    done = 1;
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/d_latch.md
# d_latch

Level-sensitive D latch with a complementary output and an enable-qualified, active-low reset. It is the storage primitive under the latch-characterisation bench. A stimulus generator drives CLK and D. The bench prints CLK, D and Q 1 ns after any of them changes. Q is then compared against the transparent/hold rules below.

## Interface
Parameters:
- WIDTH, default 1: number of independent latch bits; all bits share CLK and RSTn.
- RESET_VALUE, default {WIDTH{1'b0}}: value loaded into Q by reset.

Ports:
- CLK, input, 1: one clock; latch enable, transparent while 1, holding while 0.
- RSTn, input, 1: reset is synchronous and active-low; sampled only while CLK = 1.
- D, input, WIDTH: data input.
- Q, output, WIDTH: latched data.
- Qb, output, WIDTH: bitwise complement of Q; may be left unconnected.

## Operation
- Transparent phase (CLK = 1, RSTn = 1): Q follows D combinationally. Every D change propagates to Q.
- Hold phase (CLK = 0): Q keeps the D value that was present at the CLK 1→0 transition. D changes are ignored.
- Reset (RSTn = 0 while CLK = 1): Q = RESET_VALUE and Qb = ~RESET_VALUE, regardless of D.
  - Reset has precedence over D for as long as both CLK = 1 and RSTn = 0 hold.
- RSTn = 0 while CLK = 0: no effect. Q holds. This is what makes the reset synchronous to the enable.
- RSTn rising while CLK = 1: Q immediately returns to following D.
- CLK falling while RSTn = 0: Q holds RESET_VALUE through the hold phase.
- Qb is exactly ~Q at all times once Q is known. There is never a state with Q = Qb.
- Power-up: Q and Qb are X until the first transparent phase, where either D or reset defines them. There is no implicit initial value.
- Bits are independent. Bit i of Q depends only on bit i of D, plus CLK and RSTn.
- Internal structure: per bit, a gated SR latch built from cross-coupled NAND gates plus the reset gating. A behavioural always @* with an if (CLK) block is acceptable provided all rules above hold exactly. Flip-flop (edge-triggered) inference is forbidden.

## Timing
- Combinational paths D→Q, CLK→Q and RSTn→Q settle in under 1 ns. Zero delay is the reference behaviour.
- Qb settles no later than Q.
- D must be stable for ≥1 ns before and after the CLK 1→0 edge.
  - A D change in the same timestep as the falling CLK edge gives an unspecified Q.
  - The bench must not generate that case.
- RSTn must meet the same ≥1 ns window around the CLK 1→0 edge.
- There are no cycle latencies. Output changes are level-driven, not edge-counted.
- Q must be glitch-free in hold: toggling D any number of times while CLK = 0 produces no Q event.

## Test plan
- Transparency:
  - Stimulus: CLK = 1, RSTn = 1, D steps 0→1→0→1 at 10 ns intervals.
  - Response: Q reads 0, 1, 0, 1 at 1 ns after each step; Qb is the complement.
- Hold:
  - Stimulus: CLK = 1, D = 1; CLK falls; then D toggles 0,1,0 while CLK = 0.
  - Response: Q stays 1 at every print; no Q change event.
- Re-open:
  - Stimulus: from hold with Q = 1 and D = 0, CLK rises.
  - Response: Q = 0 within 1 ns.
- Reset in transparent phase:
  - Stimulus: CLK = 1, D = 1, Q = 1; RSTn drops to 0.
  - Response: Q = RESET_VALUE (0) and Qb = 1; D toggling has no effect.
  - Stimulus: RSTn rises with D = 1.
  - Response: Q = 1.
- Reset in hold phase:
  - Stimulus: CLK = 0, Q = 1; RSTn pulses low for 5 ns.
  - Response: Q stays 1.
  - Stimulus: CLK rises with RSTn = 0.
  - Response: Q = 0.
- Multi-bit (WIDTH = 4):
  - Stimulus: CLK = 1, D = 4'b1010; CLK falls; D = 4'b0101.
  - Response: Q = 4'b1010 and Qb = 4'b0101.
  - Stimulus: CLK rises.
  - Response: Q = 4'b0101.
